// File: rtl/sevseg_text_scroller.sv
// Buffers a software-written ASCII string and scrolls it right-to-left across an
// 8-digit seven-segment display controller at a programmable step rate.
module sevseg_text_scroller #(
  parameter int unsigned BUF_DEPTH = 16,
  parameter int unsigned PRESC_W   = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  output logic               wr_ready,
  input  logic               clear,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  input  logic [PRESC_W-1:0] step_div,
  input  logic [7:0]         blink_mask,
  output logic               busy,
  output logic               done,
  output logic [63:0]        Digits_Reg,
  output logic [15:0]        CharEns,
  output logic [7:0]         Enables_Reg
);

  localparam int unsigned CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int unsigned IDX_W  = $clog2(BUF_DEPTH);
  localparam int unsigned STEP_W = $clog2(BUF_DEPTH + 8);
  localparam logic [7:0]  BLANK  = 8'h20;

  typedef enum logic {IDLE, SCROLL} state_e;

  state_e               state_q, state_d;
  logic [7:0]           buf_mem_q [BUF_DEPTH];
  logic [7:0]           buf_mem_d [BUF_DEPTH];
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     len_q, len_d;
  logic [PRESC_W-1:0]   div_q, div_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [63:0]          digits_q, digits_d;
  logic [15:0]          char_ens_q, char_ens_d;
  logic [7:0]           enables_q, enables_d;
  logic                 wr_ready_q, wr_ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 wr_acc;
  logic [CNT_W-1:0]     len_start;
  logic                 tick;
  logic                 final_step;
  logic [7:0]           nxt;

  // Next-state, buffer and display-register logic
  always_comb begin
    state_d    = state_q;
    buf_mem_d  = buf_mem_q;
    count_d    = count_q;
    len_d      = len_q;
    div_d      = div_q;
    presc_d    = presc_q;
    step_d     = step_q;
    digits_d   = digits_q;
    char_ens_d = char_ens_q;
    enables_d  = enables_q;
    done_d     = 1'b0;

    wr_acc     = wr_en && !clear && (state_q == IDLE) && (count_q != CNT_W'(BUF_DEPTH));
    // A write accepted on the start edge is part of the scrolled string
    len_start  = clear ? CNT_W'(0) : count_q + CNT_W'(wr_acc);
    tick       = (presc_q == div_q);
    final_step = tick && (step_q == STEP_W'(len_q) + STEP_W'(7));
    nxt        = (step_q < STEP_W'(len_q)) ? buf_mem_q[step_q[IDX_W-1:0]] : BLANK;

    case (state_q)
      IDLE: begin
        if (clear) begin
          count_d = CNT_W'(0);
        end else if (wr_acc) begin
          buf_mem_d[count_q[IDX_W-1:0]] = wr_data;
          count_d = count_q + CNT_W'(1);
        end
        if (start && !stop && (len_start != CNT_W'(0))) begin
          state_d    = SCROLL;
          len_d      = len_start;
          div_d      = step_div;
          presc_d    = PRESC_W'(0);
          step_d     = STEP_W'(0);
          digits_d   = {8{BLANK}};
          enables_d  = 8'hFF;
          char_ens_d = {blink_mask, 8'hFF};
        end
      end
      SCROLL: begin
        if (stop) begin
          state_d    = IDLE;
          digits_d   = 64'h0;
          enables_d  = 8'h00;
          char_ens_d = 16'h0000;
        end else begin
          char_ens_d[15:8] = blink_mask;
          if (tick) begin
            presc_d  = PRESC_W'(0);
            digits_d = {digits_q[55:0], nxt};
            step_d   = step_q + STEP_W'(1);
            if (final_step) begin
              if (loop_en) begin
                step_d = STEP_W'(0);
              end else begin
                state_d    = IDLE;
                done_d     = 1'b1;
                digits_d   = 64'h0;
                enables_d  = 8'h00;
                char_ens_d = 16'h0000;
              end
            end
          end else begin
            presc_d = presc_q + PRESC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ready_d = (state_d == IDLE) && (count_d != CNT_W'(BUF_DEPTH));
    busy_d     = (state_d == SCROLL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      for (int i = 0; i < int'(BUF_DEPTH); i++) buf_mem_q[i] <= 8'h00;
      count_q    <= '0;
      len_q      <= '0;
      div_q      <= '0;
      presc_q    <= '0;
      step_q     <= '0;
      digits_q   <= '0;
      char_ens_q <= '0;
      enables_q  <= '0;
      wr_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_mem_q  <= buf_mem_d;
      count_q    <= count_d;
      len_q      <= len_d;
      div_q      <= div_d;
      presc_q    <= presc_d;
      step_q     <= step_d;
      digits_q   <= digits_d;
      char_ens_q <= char_ens_d;
      enables_q  <= enables_d;
      wr_ready_q <= wr_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign wr_ready    = wr_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign Digits_Reg  = digits_q;
  assign CharEns     = char_ens_q;
  assign Enables_Reg = enables_q;

endmodule
